irq_pending_ctrl: RTL and testbench

//   Interrupt front-end that sits directly upstream of the 8-to-3 priority

---
 rtl/irq_pending_ctrl.sv | 115 +++++++++++
 tb/tb_irq_pending_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - interrupt pending register and grant handshake in front of prenc83
//
// Captures request events into a pending register and drives the masked
// pending vector into an external 8-to-3 priority encoder. It takes the
// encoder's code/idle back and presents the winning line on a valid/ack
// handshake. On acknowledge it clears the granted pending bit.
//
// Parameters
//   EDGE       1 = rising-edge capture of req, 0 = level capture
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high reset
//   req        in   8  request lines, synchronous to clk
//   mask       in   8  per-line enable, 1 = enabled
//   pend       out  8  masked pending vector, feeds encoder A[7:0]
//   code       in   3  encoder Y[2:0], combinational from pend
//   idle       in   1  encoder Idle, 1 when pend is all zero
//   irq_valid  out  1  grant valid
//   irq_code   out  3  granted line index, stable while irq_valid=1
//   irq_ack    in   1  consumer accepts grant, only honoured in REQ

module irq_pending_ctrl #(
  parameter int EDGE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  output logic [7:0] pend,
  input  logic [2:0] code,
  input  logic       idle,
  output logic       irq_valid,
  output logic [2:0] irq_code,
  input  logic       irq_ack
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_REQ  = 1'b1;

  logic       state;
  logic [7:0] req_q;
  logic [7:0] pending;
  logic [7:0] ev;
  logic [7:0] clr;
  logic [7:0] pending_next;
  logic       accept;

  // req_q keeps tracking req even while reset is asserted, so a line that
  // is already high when reset releases is not mistaken for a new edge.
  always_ff @(posedge clk) begin
    req_q <= req;
  end

  generate
    if (EDGE != 0) begin : g_edge
      assign ev = req & ~req_q;
    end else begin : g_level
      assign ev = req;
    end
  endgenerate

  assign accept = (state == ST_REQ) && irq_ack;

  // The clear term is applied before the set term, so an event arriving on
  // the granted line in the ack cycle keeps that line pending.
  always_comb begin
    clr = 8'h00;
    if (accept) begin
      clr = 8'h01 << irq_code;
    end
    pending_next = (pending & ~clr) | ev;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 8'h00;
    end else begin
      pending <= pending_next;
    end
  end

  // Masked lines stay in the pending register and reappear once unmasked.
  assign pend = pending & mask;

  // The grant decision uses the encoder's idle, never code==0, because
  // code 0 is a legitimate winner (line 0). Once in REQ the code is frozen
  // until ack, whatever happens to pend in the meantime.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      irq_code <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!idle) begin
            irq_code <= code;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Returning to IDLE on ack forces at least one cycle with
          // irq_valid low before the next grant.
          if (irq_ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign irq_valid = (state == ST_REQ);

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb/tb_irq_pending_ctrl.sv - scoreboard bench for irq_pending_ctrl with a behavioural prenc83

module tb_irq_pending_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] mask;
  logic [7:0] pend;
  logic [2:0] code;
  logic       idle;
  logic       irq_valid;
  logic [2:0] irq_code;
  logic       irq_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  irq_pending_ctrl #(.EDGE(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .mask      (mask),
    .pend      (pend),
    .code      (code),
    .idle      (idle),
    .irq_valid (irq_valid),
    .irq_code  (irq_code),
    .irq_ack   (irq_ack)
  );

  // prenc83 behaviour: highest set input wins, Idle when all inputs are zero
  always_comb begin
    code = 3'd0;
    idle = (pend == 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (pend[i]) code = i[2:0];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // one-cycle pulse on req; returns just after the capturing edge
  task automatic pulse(input logic [7:0] bits);
    req = bits;
    cyc();
    req = 8'h00;
  endtask

  task automatic expect_grant(input string tag);
    bit got;
    int expv;
    got = 1'b0;
    for (int n = 0; n < 12 && !got; n++) begin
      @(negedge clk);
      if (irq_valid) got = 1'b1;
    end
    check({tag, " valid"}, {31'd0, got}, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      expv = exp_q.pop_front();
      if (got) check({tag, " code"}, {29'd0, irq_code}, expv);
    end
  endtask

  // ack the current grant; returns at the negedge after the accepting edge
  task automatic do_ack(input string tag);
    cyc();
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    @(negedge clk);
    check({tag, " valid after ack"}, {31'd0, irq_valid}, 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    req     = 8'h81;
    mask    = 8'hFF;
    irq_ack = 1'b0;

    // 1: level held through and after reset is not an edge
    repeat (3) cyc();
    @(negedge clk);
    check("t1 reset pend", {24'd0, pend}, 32'h0);
    check("t1 reset valid", {31'd0, irq_valid}, 32'd0);
    check("t1 reset code", {29'd0, irq_code}, 32'd0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1 held pend", {24'd0, pend}, 32'h0);
      check("t1 held valid", {31'd0, irq_valid}, 32'd0);
    end
    cyc();
    req = 8'h00;
    repeat (2) cyc();

    // 2: single pulse, latency and clear
    pulse(8'h20);
    exp_q.push_back(5);
    @(negedge clk);
    check("t2 pend", {24'd0, pend}, 32'h20);
    check("t2 valid early", {31'd0, irq_valid}, 32'd0);
    @(negedge clk);
    check("t2 latency valid", {31'd0, irq_valid}, 32'd1);
    expect_grant("t2");
    do_ack("t2");
    check("t2 pend after ack", {24'd0, pend}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2 stays idle", {31'd0, irq_valid}, 32'd0);
    end

    // 3: two lines together, priority order with a gap between grants
    cyc();
    pulse(8'h44);
    exp_q.push_back(6);
    exp_q.push_back(2);
    expect_grant("t3 first");
    do_ack("t3 first");
    expect_grant("t3 second");
    do_ack("t3 second");
    check("t3 pend empty", {24'd0, pend}, 32'h0);

    // 4: masked line 0 stays hidden, appears when unmasked
    cyc();
    mask = 8'hFE;
    pulse(8'h01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4 masked pend", {24'd0, pend}, 32'h0);
      check("t4 masked valid", {31'd0, irq_valid}, 32'd0);
    end
    cyc();
    mask = 8'hFF;
    exp_q.push_back(0);
    @(negedge clk);
    check("t4 unmasked pend", {24'd0, pend}, 32'h01);
    check("t4 encoder idle", {31'd0, idle}, 32'd0);
    expect_grant("t4");
    do_ack("t4");

    // 5: higher-priority arrival does not disturb an outstanding grant
    cyc();
    pulse(8'h08);
    exp_q.push_back(3);
    expect_grant("t5 first");
    cyc();
    pulse(8'h80);
    exp_q.push_back(7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5 frozen code", {29'd0, irq_code}, 32'd3);
      check("t5 held valid", {31'd0, irq_valid}, 32'd1);
    end
    do_ack("t5 first");
    expect_grant("t5 second");
    do_ack("t5 second");

    // 6: new edge on the granted line in the ack cycle re-pends it
    cyc();
    pulse(8'h08);
    exp_q.push_back(3);
    expect_grant("t6 first");
    cyc();
    irq_ack = 1'b1;
    req     = 8'h08;
    cyc();
    irq_ack = 1'b0;
    req     = 8'h00;
    exp_q.push_back(3);
    @(negedge clk);
    check("t6 valid gap", {31'd0, irq_valid}, 32'd0);
    check("t6 repend", {24'd0, pend}, 32'h08);
    expect_grant("t6 second");

    // reset during REQ drops valid and discards pending
    cyc();
    pulse(8'h10);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("t6 reset valid", {31'd0, irq_valid}, 32'd0);
    check("t6 reset pend", {24'd0, pend}, 32'h0);
    repeat (3) @(negedge clk);
    check("t6 post reset valid", {31'd0, irq_valid}, 32'd0);
    check("t6 queue drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
